// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3, rw_mode, exception and state codes shared by the LSU and data_memory
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RW_WORD = 2'b00;
    localparam logic [1:0] RW_HALF = 2'b01;
    localparam logic [1:0] RW_BYTE = 2'b10;
    localparam logic [1:0] RW_NONE = 2'b11;

    localparam logic [1:0] EXC_OK       = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_FAULT    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD_ADDR,
        ST_LOAD_DATA,
        ST_RESP
    } lsu_state_e;

    // funct3[1:0] selects access size for both loads and stores
    function automatic logic [1:0] rw_mode_of(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return RW_BYTE;
            2'b01:   return RW_HALF;
            default: return RW_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// rtl/load_store_unit_load_extender.sv - sign/zero extension of LSB-aligned load data by funct3
import load_store_unit_pkg::*;

module load_extender (
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = raw_i;
        case (funct3_i)
            F3_B:    result_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    result_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   result_o = {24'h0, raw_i[7:0]};
            F3_HU:   result_o = {16'h0, raw_i[15:0]};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store sequencer onto the data_memory port
import load_store_unit_pkg::*;

module load_store_unit #(
    parameter int DMEM_DATA_WIDTH = 32,
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_is_store,
    input  logic [2:0]                 req_funct3,
    input  logic [31:0]                req_base,
    input  logic [11:0]                req_offset,
    input  logic [31:0]                req_wdata,
    input  logic [4:0]                 req_rd,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [4:0]                 resp_rd,
    output logic [31:0]                resp_data,
    output logic [31:0]                resp_addr,
    output logic [1:0]                 resp_exc,
    output logic                       dmem_wr_en,
    output logic [1:0]                 dmem_rw_mode,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DMEM_DATA_WIDTH-1:0] dmem_w_data,
    input  logic [DMEM_DATA_WIDTH-1:0] dmem_r_data
);

    lsu_state_e                 state_q;
    logic                       wr_en_q;
    logic [1:0]                 rw_mode_q;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [DMEM_DATA_WIDTH-1:0] w_data_q;
    logic [2:0]                 funct3_q;
    logic [4:0]                 resp_rd_q;
    logic [31:0]                resp_data_q;
    logic [31:0]                resp_addr_q;
    logic [1:0]                 resp_exc_q;

    logic [31:0] ea;
    logic        illegal, misaligned, out_of_range;
    logic [1:0]  chk_exc_d;
    logic [31:0] ext_data;

    assign ea = req_base + {{20{req_offset[11]}}, req_offset};

    always_comb begin
        if (req_is_store)
            illegal = req_funct3[2] | (req_funct3 == 3'b011);
        else
            illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        misaligned   = ((req_funct3[1:0] == 2'b01) & ea[0])
                     | ((req_funct3[1:0] == 2'b10) & (ea[1:0] != 2'b00));
        out_of_range = |ea[31:DMEM_ADDR_WIDTH];
        chk_exc_d    = EXC_OK;
        if (illegal)           chk_exc_d = EXC_ILLEGAL;
        else if (misaligned)   chk_exc_d = EXC_MISALIGN;
        else if (out_of_range) chk_exc_d = EXC_FAULT;
    end

    load_extender u_load_extender (
        .funct3_i (funct3_q),
        .raw_i    (dmem_r_data[31:0]),
        .result_o (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            rw_mode_q   <= RW_NONE;
            addr_q      <= '0;
            w_data_q    <= '0;
            funct3_q    <= 3'b000;
            resp_rd_q   <= 5'd0;
            resp_data_q <= 32'd0;
            resp_addr_q <= 32'd0;
            resp_exc_q  <= EXC_OK;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    resp_rd_q   <= req_rd;
                    resp_addr_q <= ea;
                    resp_data_q <= 32'd0;
                    funct3_q    <= req_funct3;
                    resp_exc_q  <= chk_exc_d;
                    if (chk_exc_d != EXC_OK) begin
                        state_q <= ST_RESP;
                    end else begin
                        addr_q    <= ea[DMEM_ADDR_WIDTH-1:0];
                        rw_mode_q <= rw_mode_of(req_funct3[1:0]);
                        if (req_is_store) begin
                            w_data_q <= req_wdata;
                            wr_en_q  <= 1'b1;
                            state_q  <= ST_STORE;
                        end else begin
                            state_q  <= ST_LOAD_ADDR;
                        end
                    end
                end
                ST_STORE: begin
                    wr_en_q   <= 1'b0;
                    rw_mode_q <= RW_NONE;
                    state_q   <= ST_RESP;
                end
                ST_LOAD_ADDR: state_q <= ST_LOAD_DATA;
                // read data for the address driven in LOAD_ADDR is valid now
                ST_LOAD_DATA: begin
                    resp_data_q <= ext_data;
                    rw_mode_q   <= RW_NONE;
                    state_q     <= ST_RESP;
                end
                ST_RESP: if (resp_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rd      = resp_rd_q;
    assign resp_data    = resp_data_q;
    assign resp_addr    = resp_addr_q;
    assign resp_exc     = resp_exc_q;
    assign dmem_wr_en   = wr_en_q & ~rst;
    assign dmem_rw_mode = rw_mode_q;
    assign dmem_addr    = addr_q;
    assign dmem_w_data  = w_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench with byte-array memory reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_base = 32'd0;
    logic [11:0] req_offset = 12'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic [1:0]  resp_exc;
    logic        dmem_wr_en;
    logic [1:0]  dmem_rw_mode;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_w_data;
    logic [31:0] dmem_r_data = 32'd0;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.DMEM_DATA_WIDTH(32), .DMEM_ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_addr(resp_addr), .resp_exc(resp_exc),
        .dmem_wr_en(dmem_wr_en), .dmem_rw_mode(dmem_rw_mode), .dmem_addr(dmem_addr),
        .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: synchronous write, one-cycle registered read
    bit [7:0] dmem [4096];
    always @(posedge clk) begin
        if (dmem_wr_en) begin
            dmem[int'(dmem_addr)] <= dmem_w_data[7:0];
            if (dmem_rw_mode != 2'b10) dmem[int'(dmem_addr) + 1] <= dmem_w_data[15:8];
            if (dmem_rw_mode == 2'b00) begin
                dmem[int'(dmem_addr) + 2] <= dmem_w_data[23:16];
                dmem[int'(dmem_addr) + 3] <= dmem_w_data[31:24];
            end
        end
        if (dmem_rw_mode == 2'b10)
            dmem_r_data <= {24'h0, dmem[int'(dmem_addr)]};
        else if (dmem_rw_mode == 2'b01)
            dmem_r_data <= {16'h0, dmem[int'(dmem_addr) + 1], dmem[int'(dmem_addr)]};
        else if (dmem_rw_mode == 2'b00)
            dmem_r_data <= {dmem[int'(dmem_addr) + 3], dmem[int'(dmem_addr) + 2],
                            dmem[int'(dmem_addr) + 1], dmem[int'(dmem_addr)]};
    end

    // bus activity monitor
    int          wr_cnt = 0;
    int          act_cnt = 0;
    logic [11:0] seen_addr = 12'd0;
    logic [1:0]  seen_mode = 2'b11;
    logic [31:0] seen_data = 32'd0;
    always @(negedge clk) begin
        if (dmem_rw_mode != 2'b11) act_cnt++;
        if (dmem_wr_en) begin
            wr_cnt++;
            seen_addr = dmem_addr;
            seen_mode = dmem_rw_mode;
            seen_data = dmem_w_data;
        end
    end

    bit [7:0] ref_mem [4096];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit is_store, input logic [2:0] f3, input logic [31:0] base,
                          input logic [11:0] off, input logic [31:0] wdata, input logic [4:0] rd,
                          input int hold);
        int          soff, size, lat, wr0, act0, wait_n;
        logic [31:0] ea, exp_data, mask;
        logic [1:0]  exp_exc, exp_mode;
        bit          illegal;

        soff = int'($signed(off));
        ea   = base + soff;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (is_store) illegal = !(f3 inside {3'd0, 3'd1, 3'd2});
        else          illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (illegal)                      exp_exc = 2'b11;
        else if ((ea % size) != 0)        exp_exc = 2'b01;
        else if (ea >= 32'd4096)          exp_exc = 2'b10;
        else                              exp_exc = 2'b00;
        exp_mode = (size == 1) ? 2'b10 : (size == 2) ? 2'b01 : 2'b00;
        exp_data = 32'd0;
        if (exp_exc == 2'b00) begin
            if (is_store) begin
                for (int i = 0; i < size; i++) ref_mem[int'(ea) + i] = 8'(wdata >> (8 * i));
            end else begin
                for (int i = 0; i < size; i++) exp_data = exp_data | (32'(ref_mem[int'(ea) + i]) << (8 * i));
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
                if (!f3[2] && exp_data[8 * size - 1]) exp_data = exp_data | ~mask;
            end
        end

        wait_n = 0;
        while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_is_store = is_store; req_funct3 = f3; req_base = base;
        req_offset = off; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
        wr0 = wr_cnt; act0 = act_cnt;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (resp_valid) break;
        end
        chk("latency", 32'(lat), (exp_exc != 2'b00) ? 32'd1 : is_store ? 32'd2 : 32'd3);
        chk("resp_exc", {30'd0, resp_exc}, {30'd0, exp_exc});
        chk("resp_addr", resp_addr, ea);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        chk("resp_data", resp_data, exp_data);
        chk("wr_cycles", 32'(wr_cnt - wr0), (exp_exc == 2'b00 && is_store) ? 32'd1 : 32'd0);
        chk("bus_cycles", 32'(act_cnt - act0), (exp_exc != 2'b00) ? 32'd0 : is_store ? 32'd1 : 32'd2);
        if (exp_exc == 2'b00 && is_store) begin
            chk("st_addr", {20'd0, seen_addr}, ea);
            chk("st_mode", {30'd0, seen_mode}, {30'd0, exp_mode});
            chk("st_data", seen_data, wdata);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", resp_data, exp_data);
            chk("hold_exc", {30'd0, resp_exc}, {30'd0, exp_exc});
            chk("hold_addr", resp_addr, ea);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_mode", {30'd0, dmem_rw_mode}, 32'd3);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic reset_during_store();
        req_is_store = 1'b1; req_funct3 = 3'b010; req_base = 32'h140;
        req_offset = 12'd0; req_wdata = 32'h1234_5678; req_rd = 5'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_wr_en", {31'd0, dmem_wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_wr_gated", {31'd0, dmem_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mode", {30'd0, dmem_rw_mode}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready0", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid0", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data0", resp_data, 32'd0);
        chk("rst_resp_addr0", resp_addr, 32'd0);
        chk("rst_resp_misc0", {25'd0, resp_rd, resp_exc}, 32'd0);
        chk("rst_wr_en0", {31'd0, dmem_wr_en}, 32'd0);
        chk("rst_mode0", {30'd0, dmem_rw_mode}, 32'd3);
        chk("rst_addr0", {20'd0, dmem_addr}, 32'd0);
        chk("rst_wdata0", dmem_w_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 3'b010, 32'h100, 12'd4, 32'hDEAD_BEEF, 5'd1, 0);
        do_req(1'b1, 3'b000, 32'h105, 12'd0, 32'h0000_0080, 5'd2, 0);
        do_req(1'b0, 3'b000, 32'h105, 12'd0, 32'd0, 5'd3, 0);
        chk("lb_sext", resp_data, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h105, 12'd0, 32'd0, 5'd4, 0);
        chk("lbu_zext", resp_data, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h107, 12'd0, 32'd0, 5'd5, 0);
        do_req(1'b0, 3'b010, 32'h106, 12'd0, 32'd0, 5'd6, 0);
        do_req(1'b1, 3'b010, 32'h0001_0000, 12'd0, 32'hCAFE_F00D, 5'd7, 0);
        do_req(1'b0, 3'b011, 32'h101, 12'd0, 32'd0, 5'd8, 0);
        do_req(1'b0, 3'b010, 32'h200, 12'hFFC, 32'd0, 5'd10, 5);
        do_req(1'b1, 3'b001, 32'h0FFE, 12'd0, 32'h0000_9ABC, 5'd11, 1);
        do_req(1'b0, 3'b001, 32'h0FFE, 12'd0, 32'd0, 5'd12, 0);
        do_req(1'b0, 3'b010, 32'h0FFC, 12'd4, 32'd0, 5'd13, 0);

        reset_during_store();
        do_req(1'b0, 3'b010, 32'h140, 12'd0, 32'd0, 5'd14, 0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] b;
            logic [11:0] o;
            int r;
            r = int'($urandom % 16);
            if (r == 0)      b = $urandom;
            else if (r == 1) b = 32'h0000_1000 - 32'($urandom_range(0, 8));
            else             b = 32'($urandom_range(0, 255));
            o = ($urandom % 4 == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
            if ($urandom % 2 == 1) begin b = b & ~32'd3; o = o & ~12'd3; end
            do_req(1'($urandom), 3'($urandom), b, o, $urandom, 5'($urandom), int'($urandom % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
